// File: rtl/datapath_unit.sv
`default_nettype none
// ============================================================================
// Module      : datapath_unit
// Description : 16-bit processor datapath slice. Holds the instruction
//               register (IR), memory address register (MAR), a
//               combinational ALU and its result register (ALUreg). It
//               decodes IR fields for the controller and executes ALU
//               operations when the control strobes request them.
//
// Ports       : clk, rst              clock, synchronous active-high reset
//               data_bus [WIDTH]      instruction/data bus
//               out      [WIDTH]      operand bus (ALU operand A)
//               ldIR, ldMAR, ldALUreg register load strobes
//               Tlabel, mm            MAR source / ALU B operand selects
//               ALUon, fnSelect[3]    ALU enable and operation
//               ir_1..ir_4, funct     IR field slices
//               mar_q, alu_q          MAR and ALUreg contents
//               zf, cf                zero/carry flags (DATAPATH_FLAGS_EN)
//
// Options     : `define DATAPATH_FLAGS_EN adds registered zf/cf outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_bus,
    input  logic [WIDTH-1:0] out,
    input  logic             ldIR,
    input  logic             ldMAR,
    input  logic             Tlabel,
    input  logic             mm,
    input  logic             ALUon,
    input  logic [2:0]       fnSelect,
    input  logic             ldALUreg,
    output logic [3:0]       ir_1,
    output logic [1:0]       ir_2,
    output logic [1:0]       ir_3,
    output logic [2:0]       ir_4,
    output logic [2:0]       funct,
    output logic [WIDTH-1:0] mar_q,
`ifdef DATAPATH_FLAGS_EN
    output logic             zf,
    output logic             cf,
`endif
    output logic [WIDTH-1:0] alu_q
);

    localparam logic [2:0] c_FN_ADD = 3'b000;
    localparam logic [2:0] c_FN_SUB = 3'b001;
    localparam logic [2:0] c_FN_AND = 3'b010;
    localparam logic [2:0] c_FN_OR  = 3'b011;
    localparam logic [2:0] c_FN_XOR = 3'b100;
    localparam logic [2:0] c_FN_NOT = 3'b101;
    localparam logic [2:0] c_FN_SHL = 3'b110;
    localparam logic [2:0] c_FN_SHR = 3'b111;

    logic [WIDTH-1:0] ir_q, ir_d;
    logic [WIDTH-1:0] mar_d;
    logic [WIDTH-1:0] alu_d;

    logic [WIDTH-1:0] w_imm;
    logic [WIDTH-1:0] w_label;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_wide;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_cf;

    // Field slices come straight off the registered IR.
    assign ir_1  = ir_q[15:12];
    assign ir_2  = ir_q[11:10];
    assign ir_3  = ir_q[9:8];
    assign ir_4  = ir_q[7:5];
    assign funct = ir_q[2:0];

    assign w_imm   = {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]};
    assign w_label = {{(WIDTH-12){1'b0}}, ir_q[11:0]};
    assign w_b     = mm ? data_bus : w_imm;

    // ALU: the extra top bit of w_wide captures carry-out on add and
    // borrow on subtract.
    always_comb begin
        w_wide    = '0;
        w_alu_res = '0;
        w_alu_cf  = 1'b0;
        case (fnSelect)
            c_FN_ADD: begin
                w_wide    = {1'b0, out} + {1'b0, w_b};
                w_alu_res = w_wide[WIDTH-1:0];
                w_alu_cf  = w_wide[WIDTH];
            end
            c_FN_SUB: begin
                w_wide    = {1'b0, out} - {1'b0, w_b};
                w_alu_res = w_wide[WIDTH-1:0];
                w_alu_cf  = w_wide[WIDTH];
            end
            c_FN_AND: w_alu_res = out & w_b;
            c_FN_OR:  w_alu_res = out | w_b;
            c_FN_XOR: w_alu_res = out ^ w_b;
            c_FN_NOT: w_alu_res = ~out;
            c_FN_SHL: begin
                w_alu_res = {out[WIDTH-2:0], 1'b0};
                w_alu_cf  = out[WIDTH-1];
            end
            c_FN_SHR: begin
                w_alu_res = {1'b0, out[WIDTH-1:1]};
                w_alu_cf  = out[0];
            end
            default: begin
                w_alu_res = '0;
                w_alu_cf  = 1'b0;
            end
        endcase
        if (!ALUon) begin
            w_alu_res = '0;
            w_alu_cf  = 1'b0;
        end
    end

    // Next-state selection. Every source reads pre-edge register values,
    // so same-cycle loads never see each other's new contents.
    always_comb begin
        ir_d  = ir_q;
        mar_d = mar_q;
        alu_d = alu_q;
        if (ldIR) begin
            ir_d = data_bus;
        end
        if (ldMAR) begin
            if (Tlabel) begin
                mar_d = w_label;
            end else if (mm) begin
                mar_d = alu_q;
            end else begin
                mar_d = data_bus;
            end
        end
        if (ldALUreg) begin
            alu_d = w_alu_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ir_q  <= '0;
            mar_q <= '0;
            alu_q <= '0;
        end else begin
            ir_q  <= ir_d;
            mar_q <= mar_d;
            alu_q <= alu_d;
        end
    end

`ifdef DATAPATH_FLAGS_EN
    logic zf_d, cf_d;

    always_comb begin
        zf_d = zf;
        cf_d = cf;
        if (ldALUreg) begin
            zf_d = (w_alu_res == '0);
            cf_d = w_alu_cf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zf <= 1'b0;
            cf <= 1'b0;
        end else begin
            zf <= zf_d;
            cf <= cf_d;
        end
    end
`else
    // Carry logic is shared with the flagged build; nothing consumes it here.
    logic w_unused_cf;
    assign w_unused_cf = w_alu_cf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_datapath_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath_unit
// Description : Self-checking bench for datapath_unit. Directed scenarios
//               followed by randomized strobes/buses, compared every cycle
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_bus;
    logic [15:0] out;
    logic        ldIR, ldMAR, Tlabel, mm, ALUon, ldALUreg;
    logic [2:0]  fnSelect;
    logic [3:0]  ir_1;
    logic [1:0]  ir_2, ir_3;
    logic [2:0]  ir_4, funct;
    logic [15:0] mar_q, alu_q;
`ifdef DATAPATH_FLAGS_EN
    logic        zf, cf;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] m_ir, m_mar, m_alu;
    logic        m_zf, m_cf;

    always #5 clk = ~clk;

    datapath_unit #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_bus (data_bus),
        .out      (out),
        .ldIR     (ldIR),
        .ldMAR    (ldMAR),
        .Tlabel   (Tlabel),
        .mm       (mm),
        .ALUon    (ALUon),
        .fnSelect (fnSelect),
        .ldALUreg (ldALUreg),
        .ir_1     (ir_1),
        .ir_2     (ir_2),
        .ir_3     (ir_3),
        .ir_4     (ir_4),
        .funct    (funct),
        .mar_q    (mar_q),
`ifdef DATAPATH_FLAGS_EN
        .zf       (zf),
        .cf       (cf),
`endif
        .alu_q    (alu_q)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_strobes();
        rst = 1'b0; ldIR = 1'b0; ldMAR = 1'b0; Tlabel = 1'b0; mm = 1'b0;
        ALUon = 1'b0; ldALUreg = 1'b0; fnSelect = 3'b000;
    endtask

    // Applies one clock edge with the current inputs, advances the model
    // from the spec's rules, then compares every output against it.
    task automatic tick();
        int unsigned a, b, res, wide;
        logic        c;
        logic [15:0] n_ir, n_mar, n_alu;
        logic        n_zf, n_cf;

        a = out;
        if (mm) b = data_bus;
        else    b = (m_ir[7] ? 32'hFF00 : 32'h0) + m_ir[7:0];
        c = 1'b0;
        case (fnSelect)
            3'd0: begin wide = a + b; res = wide % 65536; c = (wide > 65535); end
            3'd1: begin res = (a + 65536 - b) % 65536; c = (a < b); end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = 65535 - a;
            3'd6: begin res = (a * 2) % 65536; c = (a >= 32768); end
            default: begin res = a / 2; c = a % 2; end
        endcase
        if (!ALUon) begin res = 0; c = 1'b0; end

        n_ir  = ldIR ? data_bus : m_ir;
        n_mar = m_mar;
        if (ldMAR) n_mar = Tlabel ? (m_ir % 4096) : (mm ? m_alu : data_bus);
        n_alu = m_alu;
        n_zf  = m_zf;
        n_cf  = m_cf;
        if (ldALUreg) begin
            n_alu = res[15:0];
            n_zf  = (res == 0);
            n_cf  = c;
        end

        @(posedge clk);
        if (rst) begin
            m_ir = '0; m_mar = '0; m_alu = '0; m_zf = 1'b0; m_cf = 1'b0;
        end else begin
            m_ir = n_ir; m_mar = n_mar; m_alu = n_alu; m_zf = n_zf; m_cf = n_cf;
        end
        #1;
        check("opcode", 32'(ir_1),  32'(m_ir / 4096));
        check("ir_2",   32'(ir_2),  32'((m_ir / 1024) % 4));
        check("ir_3",   32'(ir_3),  32'((m_ir / 256) % 4));
        check("ir_4",   32'(ir_4),  32'((m_ir / 32) % 8));
        check("funct",  32'(funct), 32'(m_ir % 8));
        check("mar",    32'(mar_q), 32'(m_mar));
        check("alureg", 32'(alu_q), 32'(m_alu));
`ifdef DATAPATH_FLAGS_EN
        check("zf",     32'(zf),    32'(m_zf));
        check("cf",     32'(cf),    32'(m_cf));
`endif
    endtask

    initial begin
        m_ir = '0; m_mar = '0; m_alu = '0; m_zf = 1'b0; m_cf = 1'b0;
        data_bus = 16'hA5A5; out = 16'h5A5A;

        // Reset with every strobe asserted
        rst = 1'b1; ldIR = 1'b1; ldMAR = 1'b1; Tlabel = 1'b1; mm = 1'b1;
        ALUon = 1'b1; ldALUreg = 1'b1; fnSelect = 3'b000;
        tick();
        check("rst_mar", 32'(mar_q), 32'h0);
        check("rst_alu", 32'(alu_q), 32'h0);
        check("rst_ir1", 32'(ir_1),  32'h0);

        // IR decode
        clear_strobes();
        data_bus = 16'hF155; ldIR = 1'b1;
        tick();
        check("dec_ir1", 32'(ir_1),  32'hF);
        check("dec_ir3", 32'(ir_3),  32'h1);
        check("dec_ir4", 32'(ir_4),  32'h2);
        check("dec_fn",  32'(funct), 32'h5);

        // ALU xor
        clear_strobes();
        out = 16'hF157; data_bus = 16'hF155; mm = 1'b1; ALUon = 1'b1;
        fnSelect = 3'b100; ldALUreg = 1'b1;
        tick();
        check("xor", 32'(alu_q), 32'h0002);

        // Label to MAR uses the pre-edge IR while IR reloads
        clear_strobes();
        data_bus = 16'hF755; ldIR = 1'b1; ldMAR = 1'b1; Tlabel = 1'b1; mm = 1'b1;
        tick();
        check("label_mar", 32'(mar_q), 32'h0155);
        check("label_ir2", 32'(ir_2),  32'h1);
        check("label_ir3", 32'(ir_3),  32'h3);

        // ALUon gating, then add wrap-around
        clear_strobes();
        out = 16'h1234; ldALUreg = 1'b1; ALUon = 1'b0; fnSelect = 3'b011;
        tick();
        check("gate", 32'(alu_q), 32'h0);
        ALUon = 1'b1; fnSelect = 3'b000; out = 16'hFFFF; mm = 1'b1; data_bus = 16'h0001;
        tick();
        check("wrap", 32'(alu_q), 32'h0);
`ifdef DATAPATH_FLAGS_EN
        check("wrap_zf", 32'(zf), 32'h1);
        check("wrap_cf", 32'(cf), 32'h1);
`endif

        // MAR mux: ALUreg, data_bus, hold
        clear_strobes();
        out = 16'hF157; data_bus = 16'hF155; mm = 1'b1; ALUon = 1'b1;
        fnSelect = 3'b100; ldALUreg = 1'b1;
        tick();
        clear_strobes();
        ldMAR = 1'b1; mm = 1'b1; data_bus = 16'hBEEF;
        tick();
        check("mar_alu", 32'(mar_q), 32'h0002);
        mm = 1'b0; data_bus = 16'h1234;
        tick();
        check("mar_bus", 32'(mar_q), 32'h1234);
        ldMAR = 1'b0; data_bus = 16'h5555;
        tick();
        check("mar_hold", 32'(mar_q), 32'h1234);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            rst      = ($urandom_range(0, 31) == 0);
            ldIR     = $urandom_range(0, 1);
            ldMAR    = $urandom_range(0, 1);
            Tlabel   = $urandom_range(0, 1);
            mm       = $urandom_range(0, 1);
            ALUon    = ($urandom_range(0, 7) != 0);
            ldALUreg = $urandom_range(0, 1);
            fnSelect = 3'($urandom_range(0, 7));
            data_bus = 16'($urandom);
            out      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
